blue_move: RTL
==============

BLUE_MOVE -- requirements
Module: blue_move

Interface
REQ-001 Parameters: X0=100 (start x); Y0=400 (start y); GROUND_Y=400 (sprite top when standing); SPEED=2 (px/frame); JUMP_V=12 (initial rise speed); VMAX=8 (fall speed cap).
REQ-002 Sprite box is fixed at 47 wide x 60 high; x range 0..593.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 frame_tick  in  1  one-cycle pulse per game frame; all motion updates occur only on this pulse.
REQ-006 key_left  in  1  level, move left.
REQ-007 key_right  in  1  level, move right.
REQ-008 key_jump  in  1  level, jump request.
REQ-009 hcnt  in  10  current VGA pixel column.
REQ-010 vcnt  in  10  current VGA pixel row.
REQ-011 blue_x  out  10  sprite left edge.
REQ-012 blue_y  out  10  sprite top edge.
REQ-013 blue_state  out  3  bit0 direction (0 left, 1 right); bit1 airborne; bit2 moving.
REQ-014 blue  out  14  sprite ROM address, row-major with 47 pixels per row, always for a right-facing image.
REQ-015 blue_in  out  1  current pixel lies inside the sprite box.

Function
REQ-016 Vertical FSM states: GROUND, RISE, FALL; blue_state[1] SHALL be 0 in GROUND and 1 otherwise.
REQ-017 GROUND + tick + key_jump -> RISE with vy=JUMP_V; key_jump held SHALL NOT retrigger until released and pressed again (edge sampled at ticks).
REQ-018 RISE tick: y <= y-vy, vy <= vy-1; vy reaching 0 -> FALL; y underflow clamps at 0 and forces FALL with vy=0.
REQ-019 FALL tick: if y+vy >= GROUND_Y then y <= GROUND_Y, vy <= 0, -> GROUND; else y <= y+vy, vy <= min(vy+1, VMAX).
REQ-020 Horizontal tick: left only -> x -= SPEED, bit0=0, bit2=1; right only -> x += SPEED, bit0=1, bit2=1; neither or both -> x unchanged, bit2=0, bit0 held.
REQ-021 x SHALL saturate to 0..593; at a wall with a key held, bit2 SHALL stay 1 and bit0 SHALL follow the key.
REQ-022 Horizontal and vertical updates on the same tick are independent and both apply.
REQ-023 Address path (every clk, 1-cycle latency): if x<=hcnt<x+47 and y<=vcnt<y+60 then blue=(vcnt-y)*47+(hcnt-x), blue_in=1; else blue=0, blue_in=0.
REQ-024 Address arithmetic SHALL use unsigned 14-bit intermediates; max address 2819.
REQ-025 Address path SHALL use the current registered x/y; a frame_tick in the same cycle affects the following cycle only.

Reset
REQ-026 rst SHALL set x=X0, y=Y0, vy=0, state GROUND, blue_state=3'b001, blue=0, blue_in=0, and clear the jump-edge register.
REQ-027 rst mid-jump SHALL abort the jump immediately; rst has priority over frame_tick.

Configuration
REQ-028 Macro BLUE_DOUBLE_JUMP_EN: when defined, one extra jump is allowed per airborne period (a new key_jump edge in RISE or FALL sets vy=JUMP_V and enters RISE); the allowance is restored on entering GROUND; when undefined, key_jump is ignored while airborne.

Verification
REQ-029 Reset, then 5 ticks with no keys -> x=100, y=400, blue_state=001.
REQ-030 key_left for 60 ticks from x=100 -> x=0 after 50 ticks and stays 0; blue_state=100.
REQ-031 Jump edge from ground -> after 1 tick y=388, state RISE; after 12 ticks vy=0, FALL; lands at y=400 with blue_state[1]=0.
REQ-032 x=100, y=400, hcnt=110, vcnt=405 -> next cycle blue=245, blue_in=1; hcnt=147 -> blue=0, blue_in=0.
REQ-033 Second jump edge at mid-air -> with BLUE_DOUBLE_JUMP_EN, vy=12 and RISE; without it, trajectory is unchanged; a third edge is ignored in both builds.
REQ-034 Assert rst during RISE -> next cycle y=400, GROUND, blue_state=001.

Source files
------------

// File: rtl/blue_move.sv
// blue_move: movement controller and sprite address generator for the
// 47x60 "blue" character. Horizontal walking and a ground/rise/fall jump
// FSM update once per frame_tick; the ROM address path runs every clock.
// Optional feature macro: BLUE_DOUBLE_JUMP_EN (one extra mid-air jump).
module blue_move #(
  parameter int unsigned X0       = 100,
  parameter int unsigned Y0       = 400,
  parameter int unsigned GROUND_Y = 400,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned VMAX     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  output logic [9:0]  blue_x,
  output logic [9:0]  blue_y,
  output logic [2:0]  blue_state,
  output logic [13:0] blue,
  output logic        blue_in
);

  localparam logic [9:0]  X0_C       = 10'(X0);
  localparam logic [9:0]  Y0_C       = 10'(Y0);
  localparam logic [9:0]  GROUND_Y_C = 10'(GROUND_Y);
  localparam logic [9:0]  SPEED_C    = 10'(SPEED);
  localparam logic [9:0]  JUMP_V_C   = 10'(JUMP_V);
  localparam logic [9:0]  VMAX_C     = 10'(VMAX);
  localparam logic [9:0]  X_MAX_C    = 10'd593;
  localparam logic [13:0] SPRITE_W   = 14'd47;
  localparam logic [13:0] SPRITE_H   = 14'd60;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } v_state_e;

  v_state_e    state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [9:0]  vy_q, vy_d;
  logic        dir_q, dir_d;
  logic        moving_q, moving_d;
  logic        jump_prev_q, jump_prev_d;
  logic [13:0] blue_q;
  logic        blue_in_q;

  logic        jump_edge;
  logic        air_jump;
  logic [10:0] right_sum;
  logic [10:0] fall_sum;

  // A jump is a rising edge of key_jump as seen from one tick to the next.
  assign jump_edge = key_jump & ~jump_prev_q;
  assign right_sum = {1'b0, x_q} + {1'b0, SPEED_C};
  assign fall_sum  = {1'b0, y_q} + {1'b0, vy_q};

`ifdef BLUE_DOUBLE_JUMP_EN
  logic dj_used_q;

  // Track whether the single mid-air jump has been spent this airborne period.
  always_ff @(posedge clk) begin
    if (rst) begin
      dj_used_q <= 1'b0;
    end else if (frame_tick) begin
      if (state_d == GROUND) dj_used_q <= 1'b0;
      else if (air_jump)     dj_used_q <= 1'b1;
    end
  end

  assign air_jump = jump_edge & ~dj_used_q & (state_q != GROUND);
`else
  assign air_jump = 1'b0;
`endif

  // Next-state logic for position, velocity, facing and the vertical FSM.
  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    dir_d       = dir_q;
    moving_d    = moving_q;
    state_d     = state_q;
    jump_prev_d = jump_prev_q;

    if (frame_tick) begin
      jump_prev_d = key_jump;

      case ({key_left, key_right})
        2'b10: begin
          dir_d    = 1'b0;
          moving_d = 1'b1;
          x_d      = (x_q < SPEED_C) ? 10'd0 : x_q - SPEED_C;
        end
        2'b01: begin
          dir_d    = 1'b1;
          moving_d = 1'b1;
          x_d      = (right_sum > {1'b0, X_MAX_C}) ? X_MAX_C : right_sum[9:0];
        end
        default: moving_d = 1'b0;
      endcase

      case (state_q)
        GROUND: begin
          if (jump_edge) begin
            state_d = RISE;
            vy_d    = JUMP_V_C;
          end
        end
        RISE: begin
          if (air_jump) begin
            vy_d = JUMP_V_C;
          end else if (vy_q > y_q) begin
            // Would rise past the top of the screen: pin to 0 and drop.
            y_d     = 10'd0;
            vy_d    = 10'd0;
            state_d = FALL;
          end else begin
            y_d  = y_q - vy_q;
            vy_d = (vy_q == 10'd0) ? 10'd0 : vy_q - 10'd1;
            if (vy_q <= 10'd1) state_d = FALL;
          end
        end
        FALL: begin
          if (air_jump) begin
            vy_d    = JUMP_V_C;
            state_d = RISE;
          end else if (fall_sum >= {1'b0, GROUND_Y_C}) begin
            y_d     = GROUND_Y_C;
            vy_d    = 10'd0;
            state_d = GROUND;
          end else begin
            y_d  = fall_sum[9:0];
            vy_d = (vy_q >= VMAX_C) ? VMAX_C : vy_q + 10'd1;
          end
        end
        default: begin
          state_d = GROUND;
          vy_d    = 10'd0;
        end
      endcase
    end
  end

  // Motion state registers; reset wins over any frame_tick in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      x_q         <= X0_C;
      y_q         <= Y0_C;
      vy_q        <= 10'd0;
      dir_q       <= 1'b1;
      moving_q    <= 1'b0;
      state_q     <= GROUND;
      jump_prev_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      dir_q       <= dir_d;
      moving_q    <= moving_d;
      state_q     <= state_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  // Sprite hit test and ROM address from the registered position.
  logic [13:0] h14, v14, x14, y14;
  logic        in_box;
  logic [13:0] addr;

  assign h14    = {4'd0, hcnt};
  assign v14    = {4'd0, vcnt};
  assign x14    = {4'd0, x_q};
  assign y14    = {4'd0, y_q};
  assign in_box = (h14 >= x14) && (h14 < x14 + SPRITE_W) &&
                  (v14 >= y14) && (v14 < y14 + SPRITE_H);
  assign addr   = (v14 - y14) * SPRITE_W + (h14 - x14);

  // Register the address path: one cycle from hcnt/vcnt to blue/blue_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      blue_q    <= 14'd0;
      blue_in_q <= 1'b0;
    end else begin
      blue_in_q <= in_box;
      blue_q    <= in_box ? addr : 14'd0;
    end
  end

  assign blue_x     = x_q;
  assign blue_y     = y_q;
  assign blue_state = {moving_q, state_q != GROUND, dir_q};
  assign blue       = blue_q;
  assign blue_in    = blue_in_q;

endmodule
